// File: rtl/add_sub_seg_ctrl_if.sv
// Request/result bundle for the segmented add/subtract sequencer.
// The master side issues operand pairs and the slave side returns the results.
interface add_sub_seg_ctrl_if #(
  parameter int SWR = 26,
  parameter int LZW = $clog2(SWR + 1)
);
  logic           flush_i;
  logic           start_i;
  logic           op_i;
  logic [SWR-1:0] Op_A_i;
  logic [SWR-1:0] Pre_Op_B_i;
  logic           ready_o;
  logic           valid_o;
  logic [SWR-1:0] Sum_o;
  logic           Cout_o;
  logic [SWR-1:0] P_o;
  logic [LZW-1:0] LZ_o;

  modport master (
    output flush_i, start_i, op_i, Op_A_i, Pre_Op_B_i,
    input  ready_o, valid_o, Sum_o, Cout_o, P_o, LZ_o
  );

  modport slave (
    input  flush_i, start_i, op_i, Op_A_i, Pre_Op_B_i,
    output ready_o, valid_o, Sum_o, Cout_o, P_o, LZ_o
  );
endinterface

// File: rtl/add_sub_seg_ctrl.sv
// Sequencer for the segmented ripple-carry add/subtract path.
// One SEG-bit slice of the carry chain is evaluated per cycle. The carry
// between slices is held in carry_r. After the last slice, the leading-zero
// count of the full sum is taken, and a one-cycle valid pulse follows.
module add_sub_seg_ctrl #(
  parameter int SWR = 26,
  parameter int SEG = 13,
  parameter int LZW = $clog2(SWR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  add_sub_seg_ctrl_if.slave bus
);

  localparam int NSEG = (SWR + SEG - 1) / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    LZC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [SWR-1:0]  a_r;
  logic [SWR-1:0]  b_r;
  logic [SWR-1:0]  sum_r;
  logic [SWR-1:0]  p_r;
  logic [LZW-1:0]  lz_r;
  logic            cout_r;
  logic            carry_r;
  logic            ready_r;
  logic            valid_r;
  logic [IDXW-1:0] idx_r;

  // Current slice, right-aligned. Bits beyond the word end stay 0 in the mask.
  logic [SWR-1:0]  seg_sum_s;
  logic [SWR-1:0]  seg_p_s;
  logic [SWR-1:0]  seg_mask_s;
  logic            seg_cout_s;
  int              seg_base_s;

  // Counts leading zeros from the MSB; returns SWR for an all-zero word.
  function automatic logic [LZW-1:0] lz_count(input logic [SWR-1:0] v);
    logic [LZW-1:0] cnt;
    logic           found;
    cnt   = '0;
    found = 1'b0;
    for (int i = SWR - 1; i >= 0; i--) begin
      if (!found && !v[i]) begin
        cnt = cnt + LZW'(1);
      end else begin
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  // Ripple-carry over the slice selected by idx_r, seeded by the carry register.
  always_comb begin
    logic [SWR-1:0] a_sh;
    logic [SWR-1:0] b_sh;
    logic           c;
    seg_base_s = int'(idx_r) * SEG;
    a_sh       = a_r >> seg_base_s;
    b_sh       = b_r >> seg_base_s;
    c          = carry_r;
    seg_sum_s  = '0;
    seg_p_s    = '0;
    seg_mask_s = '0;
    for (int i = 0; i < SEG; i++) begin
      if (seg_base_s + i < SWR) begin
        seg_p_s[i]    = a_sh[i] ^ b_sh[i];
        seg_sum_s[i]  = seg_p_s[i] ^ c;
        c             = (a_sh[i] & b_sh[i]) | (seg_p_s[i] & c);
        seg_mask_s[i] = 1'b1;
      end else begin
        seg_mask_s[i] = 1'b0;
      end
    end
    seg_cout_s = c;
  end

  // Next-state logic. A flush returns a busy sequencer to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_i) state_s = ADD;
        else             state_s = IDLE;
      end
      ADD: begin
        if (bus.flush_i)              state_s = IDLE;
        else if (idx_r == LAST_IDX)   state_s = LZC;
        else                          state_s = ADD;
      end
      LZC: begin
        if (bus.flush_i) state_s = IDLE;
        else             state_s = DONE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Datapath registers. Handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      p_r     <= '0;
      lz_r    <= '0;
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      ready_r <= (state_s == IDLE);
      valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            a_r     <= bus.Op_A_i;
            b_r     <= bus.Pre_Op_B_i ^ {SWR{bus.op_i}};
            carry_r <= bus.op_i;
            idx_r   <= '0;
            sum_r   <= '0;
            p_r     <= '0;
          end
        end
        ADD: begin
          if (bus.flush_i) begin
            carry_r <= 1'b0;
          end else begin
            sum_r   <= (sum_r & ~(seg_mask_s << seg_base_s)) | (seg_sum_s << seg_base_s);
            p_r     <= (p_r & ~(seg_mask_s << seg_base_s)) | (seg_p_s << seg_base_s);
            carry_r <= seg_cout_s;
            if (idx_r == LAST_IDX) cout_r <= seg_cout_s;
            else                   idx_r  <= idx_r + IDXW'(1);
          end
        end
        LZC: begin
          if (bus.flush_i) carry_r <= 1'b0;
          else             lz_r    <= lz_count(sum_r);
        end
        DONE: begin
          if (bus.flush_i) carry_r <= 1'b0;
          else             carry_r <= carry_r;
        end
        default: carry_r <= 1'b0;
      endcase
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.valid_o = valid_r;
  assign bus.Sum_o   = sum_r;
  assign bus.Cout_o  = cout_r;
  assign bus.P_o     = p_r;
  assign bus.LZ_o    = lz_r;

endmodule
